// File: rtl/bias_loader_pp_pkg.sv
// Shared types and sizing helpers for the ping-pong bias loader.
package bias_loader_pp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill,
    StDone
  } load_state_e;

  function automatic int unsigned calc_pack(int unsigned bias_bits, int unsigned axi_width);
    return axi_width / bias_bits;
  endfunction

  function automatic int unsigned calc_depth(int unsigned max_och, int unsigned pack);
    return max_och / pack;
  endfunction

  function automatic int unsigned calc_och_w(int unsigned max_och);
    return $clog2(max_och) + 1;
  endfunction

  // Address width that stays legal for single-entry ranges.
  function automatic int unsigned calc_addr_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_loader_pp_if.sv
// Control, serve and DMA-read signal bundle of the ping-pong bias loader.
interface bias_loader_pp_if #(
  parameter int unsigned BIAS_BITS    = 16,
  parameter int unsigned AXI_WIDTH_DA = 32,
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned BITS_TRANS   = 18,
  parameter int unsigned MAX_OCH      = 256
);
  import bias_loader_pp_pkg::*;

  localparam int unsigned OCH_W = calc_och_w(MAX_OCH);

  logic                    ap_start;
  logic [OCH_W-1:0]        och;
  logic [AXI_WIDTH_AD-1:0] bias_start_addr;
  logic                    load_busy;
  logic                    write_done;
  logic                    layer_swap;
  logic                    bias_bank_vld;
  logic                    bias_request;
  logic                    bias_mode;
  logic [OCH_W-2:0]        bias_idx;
  logic [BIAS_BITS-1:0]    bias_o;
  logic                    bias_vld_o;
  logic                    err_o;
  logic                    start_dma;
  logic [BITS_TRANS-1:0]   dma_num_trans;
  logic [AXI_WIDTH_AD-1:0] dma_start_addr;
  logic [AXI_WIDTH_DA-1:0] dma_din;
  logic                    dma_din_vld;
  logic [BITS_TRANS-1:0]   dma_data_cnt;
  logic                    dma_done;

  modport slave (
    input  ap_start, och, bias_start_addr, layer_swap, bias_request, bias_mode, bias_idx,
           dma_din, dma_din_vld, dma_data_cnt, dma_done,
    output load_busy, write_done, bias_bank_vld, bias_o, bias_vld_o, err_o, start_dma,
           dma_num_trans, dma_start_addr
  );

  modport master (
    output ap_start, och, bias_start_addr, layer_swap, bias_request, bias_mode, bias_idx,
           dma_din, dma_din_vld, dma_data_cnt, dma_done,
    input  load_busy, write_done, bias_bank_vld, bias_o, bias_vld_o, err_o, start_dma,
           dma_num_trans, dma_start_addr
  );

endinterface

// File: rtl/bias_loader_pp_bank_ram.sv
// One bias bank: single write port, single synchronous read port.
module bias_loader_pp_bank_ram
  import bias_loader_pp_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 128,
  localparam int unsigned AddrW = calc_addr_w(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bias_loader_pp.sv
// Double-buffered bias loader: DMA fills the idle bank while the active bank serves biases.
module bias_loader_pp
  import bias_loader_pp_pkg::*;
#(
  parameter int unsigned BIAS_BITS    = 16,
  parameter int unsigned AXI_WIDTH_DA = 32,
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned BITS_TRANS   = 18,
  parameter int unsigned MAX_OCH      = 256
) (
  input logic             clk,
  input logic             rstn,
  bias_loader_pp_if.slave bus
);

  localparam int unsigned PACK   = calc_pack(BIAS_BITS, AXI_WIDTH_DA);
  localparam int unsigned DEPTH  = calc_depth(MAX_OCH, PACK);
  localparam int unsigned OCH_W  = calc_och_w(MAX_OCH);
  localparam int unsigned IDX_W  = OCH_W - 1;
  localparam int unsigned AW     = calc_addr_w(DEPTH);
  localparam int unsigned LANE_W = calc_addr_w(PACK);
  localparam logic [OCH_W-1:0] MAX_OCH_V = OCH_W'(MAX_OCH);

  load_state_e             state_q, state_d;
  logic [BITS_TRANS-1:0]   num_trans_q, num_trans_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
  logic [OCH_W-1:0]        och_fill_q, och_fill_d;
  logic [OCH_W-1:0]        och_active_q, och_active_d;
  logic [1:0]              full_q, full_d;
  logic                    active_q, active_d;
  logic                    last_q, last_d;
  logic                    done_seen_q, done_seen_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    rd_vld_q, rd_oob_q, rd_bank_q;
  logic [LANE_W-1:0]       rd_lane_q;

  logic              fill;
  logic              start_ok, swap_ok, wr_en, wr_last;
  logic [OCH_W-1:0]  och_words;
  logic              req_ok, oob, rd_en, ptr_wrap;
  logic [IDX_W-1:0]  rd_idx;
  logic [AW-1:0]     rd_addr;
  logic [LANE_W-1:0] rd_lane;

  assign fill      = ~active_q;
  assign och_words = OCH_W'((32'(bus.och) + PACK - 1) / PACK);
  assign start_ok  = (state_q == StIdle) && !full_q[fill] && (bus.och != '0) &&
                     (bus.och <= MAX_OCH_V);
  assign swap_ok   = bus.layer_swap && full_q[fill];
  // Beats outside FILL or beyond the requested word count never touch a bank.
  assign wr_en     = (state_q == StFill) && bus.dma_din_vld && (bus.dma_data_cnt < num_trans_q);
  assign wr_last   = wr_en && (bus.dma_data_cnt == num_trans_q - BITS_TRANS'(1));

  assign req_ok   = bus.bias_request && full_q[active_q];
  assign rd_idx   = bus.bias_mode ? bus.bias_idx : ptr_q;
  assign oob      = req_ok && bus.bias_mode && ({1'b0, bus.bias_idx} >= och_active_q);
  assign rd_en    = req_ok && !oob;
  assign rd_addr  = AW'(32'(rd_idx) / PACK);
  assign rd_lane  = LANE_W'(32'(rd_idx) % PACK);
  assign ptr_wrap = ({1'b0, ptr_q} == och_active_q - OCH_W'(1));

  always_comb begin
    state_d      = state_q;
    num_trans_d  = num_trans_q;
    addr_d       = addr_q;
    och_fill_d   = och_fill_q;
    och_active_d = och_active_q;
    full_d       = full_q;
    active_d     = active_q;
    last_d       = last_q;
    done_seen_d  = done_seen_q;
    ptr_d        = ptr_q;
    err_d        = (bus.ap_start && !start_ok) || oob;

    case (state_q)
      StIdle: begin
        if (bus.ap_start && start_ok) begin
          state_d     = StReq;
          num_trans_d = BITS_TRANS'(och_words);
          addr_d      = bus.bias_start_addr;
          och_fill_d  = bus.och;
          last_d      = 1'b0;
          done_seen_d = 1'b0;
        end
      end
      StReq:  state_d = StFill;
      StFill: begin
        // dma_done may arrive with or after the final beat; wait for both.
        last_d      = last_q | wr_last;
        done_seen_d = done_seen_q | bus.dma_done;
        if (last_d && done_seen_d) begin
          state_d      = StDone;
          full_d[fill] = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A request in the swap cycle still reads the old bank; the pointer restarts.
    if (swap_ok) begin
      active_d         = fill;
      och_active_d     = och_fill_q;
      full_d[active_q] = 1'b0;
      ptr_d            = '0;
    end else if (req_ok && !bus.bias_mode) begin
      ptr_d = ptr_wrap ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      num_trans_q  <= '0;
      addr_q       <= '0;
      och_fill_q   <= '0;
      och_active_q <= '0;
      full_q       <= '0;
      active_q     <= 1'b0;
      last_q       <= 1'b0;
      done_seen_q  <= 1'b0;
      err_q        <= 1'b0;
      ptr_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_oob_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_lane_q    <= '0;
    end else begin
      state_q      <= state_d;
      num_trans_q  <= num_trans_d;
      addr_q       <= addr_d;
      och_fill_q   <= och_fill_d;
      och_active_q <= och_active_d;
      full_q       <= full_d;
      active_q     <= active_d;
      last_q       <= last_d;
      done_seen_q  <= done_seen_d;
      err_q        <= err_d;
      ptr_q        <= ptr_d;
      rd_vld_q     <= req_ok;
      rd_oob_q     <= oob;
      rd_bank_q    <= active_q;
      rd_lane_q    <= rd_lane;
    end
  end

  logic [AXI_WIDTH_DA-1:0] rdata [2];
  logic [AXI_WIDTH_DA-1:0] rd_word;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bias_loader_pp_bank_ram #(
      .Width (AXI_WIDTH_DA),
      .Depth (DEPTH)
    ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_en && (fill == 1'(b))),
      .waddr_i (bus.dma_data_cnt[AW-1:0]),
      .wdata_i (bus.dma_din),
      .re_i    (rd_en && (active_q == 1'(b))),
      .raddr_i (rd_addr),
      .rdata_o (rdata[b])
    );
  end

  assign rd_word = rd_bank_q ? rdata[1] : rdata[0];

  assign bus.bias_o         = (rd_vld_q && !rd_oob_q) ?
                              rd_word[rd_lane_q * BIAS_BITS +: BIAS_BITS] : '0;
  assign bus.bias_vld_o     = rd_vld_q;
  assign bus.err_o          = err_q;
  assign bus.load_busy      = (state_q != StIdle);
  assign bus.write_done     = (state_q == StDone);
  assign bus.start_dma      = (state_q == StReq);
  assign bus.dma_num_trans  = num_trans_q;
  assign bus.dma_start_addr = addr_q;
  assign bus.bias_bank_vld  = full_q[active_q];

endmodule

// File: tb/tb_bias_loader_pp.sv
// Randomised bench for bias_loader_pp against a bank-level reference model.
module tb_bias_loader_pp;

  localparam int unsigned PACK  = 2;
  localparam int unsigned DEPTH = 128;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bias_loader_pp_if #(.BIAS_BITS(16), .AXI_WIDTH_DA(32), .AXI_WIDTH_AD(32), .BITS_TRANS(18),
                      .MAX_OCH(256)) bus ();
  bias_loader_pp_if #(.BIAS_BITS(8), .AXI_WIDTH_DA(32), .AXI_WIDTH_AD(32), .BITS_TRANS(18),
                      .MAX_OCH(256)) bus8 ();

  bias_loader_pp #(.BIAS_BITS(16), .AXI_WIDTH_DA(32), .AXI_WIDTH_AD(32), .BITS_TRANS(18),
                   .MAX_OCH(256)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  bias_loader_pp #(.BIAS_BITS(8), .AXI_WIDTH_DA(32), .AXI_WIDTH_AD(32), .BITS_TRANS(18),
                   .MAX_OCH(256)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;

  // Reference model: bank contents, layer sizes, full flags, active bank, sequential pointer.
  logic [15:0] bank_m [2][256];
  int          och_m  [2];
  bit          full_m [2];
  int          act_m;
  int          ptr_m;

  logic [7:0]  b8 [10];
  logic [31:0] w8;
  int          s0;

  always @(posedge clk) if (bus.start_dma) n_start <= n_start + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ap_start = 0; bus.och = '0; bus.bias_start_addr = '0; bus.layer_swap = 0;
    bus.bias_request = 0; bus.bias_mode = 0; bus.bias_idx = '0;
    bus.dma_din = '0; bus.dma_din_vld = 0; bus.dma_data_cnt = '0; bus.dma_done = 0;
    bus8.ap_start = 0; bus8.och = '0; bus8.bias_start_addr = '0; bus8.layer_swap = 0;
    bus8.bias_request = 0; bus8.bias_mode = 0; bus8.bias_idx = '0;
    bus8.dma_din = '0; bus8.dma_din_vld = 0; bus8.dma_data_cnt = '0; bus8.dma_done = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, bus.load_busy, 0);
    check_eq({tag, "_wdone"}, bus.write_done, 0);
    check_eq({tag, "_bank_vld"}, bus.bias_bank_vld, 0);
    check_eq({tag, "_bias"}, bus.bias_o, 0);
    check_eq({tag, "_bias_vld"}, bus.bias_vld_o, 0);
    check_eq({tag, "_err"}, bus.err_o, 0);
    check_eq({tag, "_start"}, bus.start_dma, 0);
    check_eq({tag, "_ntrans"}, bus.dma_num_trans, 0);
    check_eq({tag, "_addr"}, bus.dma_start_addr, 0);
  endtask

  task automatic model_reset();
    full_m[0] = 0; full_m[1] = 0; och_m[0] = 0; och_m[1] = 0; act_m = 0; ptr_m = 0;
  endtask

  task automatic model_swap();
    int f = 1 - act_m;
    if (full_m[f]) begin
      full_m[act_m] = 0;
      act_m = f;
      ptr_m = 0;
    end
  endtask

  task automatic do_load(input int och, input logic [31:0] addr, input bit probe_busy,
                         input bit swap_at_done);
    int          f      = 1 - act_m;
    int          nt     = (och + PACK - 1) / PACK;
    int          starts = n_start;
    int          t;
    logic [15:0] vals [256];
    logic [31:0] word;
    for (int i = 0; i < och; i++) vals[i] = 16'($urandom);
    bus.och = 9'(och); bus.bias_start_addr = addr; bus.ap_start = 1;
    step();
    bus.ap_start = 0;
    check_eq("start_dma", bus.start_dma, 1);
    check_eq("num_trans", bus.dma_num_trans, 64'(nt));
    check_eq("start_addr", bus.dma_start_addr, 64'(addr));
    step();
    if (probe_busy) begin
      bus.ap_start = 1;
      step();
      bus.ap_start = 0;
      check_eq("busy_reject_err", bus.err_o, 1);
      check_eq("busy_reject_start", bus.start_dma, 0);
    end
    // Beat past the word count whose low bits alias word 0.
    bus.dma_din = $urandom; bus.dma_data_cnt = 18'(DEPTH); bus.dma_din_vld = 1;
    step();
    bus.dma_din_vld = 0;
    for (int w = 0; w < nt; w++) begin
      if ($urandom_range(0, 3) == 0) step();
      word = '0;
      for (int k = 0; k < PACK; k++)
        word[k*16 +: 16] = (w * PACK + k < och) ? vals[w * PACK + k] : 16'($urandom);
      bus.dma_din = word; bus.dma_data_cnt = 18'(w); bus.dma_din_vld = 1;
      step();
      bus.dma_din_vld = 0;
    end
    bus.dma_done = 1;
    step();
    bus.dma_done = 0;
    t = 0;
    while (!bus.write_done && t < 16) begin
      step();
      t++;
    end
    check_eq("write_done", bus.write_done, 1);
    check_eq("one_start_dma", 64'(n_start - starts), 1);
    for (int i = 0; i < och; i++) bank_m[f][i] = vals[i];
    och_m[f]  = och;
    full_m[f] = 1;
    if (swap_at_done) begin
      bus.layer_swap = 1;
      step();
      bus.layer_swap = 0;
      model_swap();
      check_eq("swap_at_done_vld", bus.bias_bank_vld, 1);
    end else begin
      step();
    end
  endtask

  task automatic serve_seq(input int n, input bit gaps);
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.bias_request = 0;
        step();
        check_eq("seq_gap_vld", bus.bias_vld_o, 0);
      end
      exp   = bank_m[act_m][ptr_m];
      ptr_m = (ptr_m + 1) % och_m[act_m];
      bus.bias_request = 1; bus.bias_mode = 0;
      step();
      check_eq("seq_vld", bus.bias_vld_o, 1);
      check_eq("seq_bias", bus.bias_o, 64'(exp));
    end
    bus.bias_request = 0;
  endtask

  task automatic serve_idx(input int idx);
    bus.bias_request = 1; bus.bias_mode = 1; bus.bias_idx = 8'(idx);
    step();
    bus.bias_request = 0; bus.bias_mode = 0;
    check_eq("idx_vld", bus.bias_vld_o, 1);
    if (idx < och_m[act_m]) begin
      check_eq("idx_bias", bus.bias_o, 64'(bank_m[act_m][idx]));
      check_eq("idx_err", bus.err_o, 0);
    end else begin
      check_eq("oob_bias", bus.bias_o, 0);
      check_eq("oob_err", bus.err_o, 1);
    end
  endtask

  task automatic do_swap(input bit with_req);
    logic [15:0] exp = bank_m[act_m][ptr_m];
    bus.bias_request = with_req; bus.bias_mode = 0; bus.layer_swap = 1;
    step();
    bus.bias_request = 0; bus.layer_swap = 0;
    if (with_req) begin
      check_eq("swap_req_vld", bus.bias_vld_o, 1);
      check_eq("swap_req_old_bank", bus.bias_o, 64'(exp));
    end
    model_swap();
    check_eq("swap_bank_vld", bus.bias_bank_vld, 1);
  endtask

  task automatic reject_start(input int och, input string tag);
    s0 = n_start;
    bus.och = 9'(och); bus.ap_start = 1;
    step();
    bus.ap_start = 0;
    check_eq({tag, "_err"}, bus.err_o, 1);
    check_eq({tag, "_start"}, bus.start_dma, 0);
    check_eq({tag, "_busy"}, bus.load_busy, 0);
    step();
    check_eq({tag, "_no_dma"}, 64'(n_start - s0), 0);
    check_eq({tag, "_err_pulse"}, bus.err_o, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) step();
    check_idle_outputs("rst");
    rstn = 1;
    step();
    check_idle_outputs("post_rst");

    // No valid bank: request is ignored.
    bus.bias_request = 1;
    step();
    bus.bias_request = 0;
    check_eq("no_bank_vld", bus.bias_vld_o, 0);

    // Full-size layer, sequential wrap.
    do_load(256, 32'h8000_0000, 0, 0);
    check_eq("bank_vld_before_swap", bus.bias_bank_vld, 0);
    do_swap(0);
    serve_seq(257, 0);

    // Small layer, swap in the write_done cycle, indexed access.
    do_load(5, 32'h0000_1000, 0, 1);
    serve_idx(4);
    serve_idx(7);
    serve_idx(0);
    repeat (30) begin
      if ($urandom_range(0, 1) == 1) serve_idx($urandom_range(0, 7));
      else serve_seq(1, 0);
    end

    // Ping-pong: serve A while loading B.
    do_load(64, 32'h0000_2000, 1, 0);
    do_swap(0);
    fork
      serve_seq(150, 1);
      do_load(32, 32'h0000_0100, 0, 0);
    join
    reject_start(8, "full_reject");
    do_swap(1);
    serve_seq(33, 0);

    // Reset in the middle of FILL.
    bus.och = 9'd64; bus.bias_start_addr = 32'h0000_4000; bus.ap_start = 1;
    step();
    bus.ap_start = 0;
    step();
    for (int w = 0; w < 10; w++) begin
      bus.dma_din = $urandom; bus.dma_data_cnt = 18'(w); bus.dma_din_vld = 1;
      step();
    end
    bus.dma_din_vld = 0;
    rstn = 0;
    #1;
    check_idle_outputs("mid_fill_rst");
    model_reset();
    step();
    rstn = 1;
    bus.dma_din = $urandom; bus.dma_data_cnt = 18'd10; bus.dma_din_vld = 1;
    step();
    bus.dma_din_vld = 0; bus.dma_done = 1;
    step();
    bus.dma_done = 0;
    check_eq("stale_busy", bus.load_busy, 0);
    check_eq("stale_wdone", bus.write_done, 0);
    check_eq("stale_bank_vld", bus.bias_bank_vld, 0);
    reject_start(0, "och0_reject");
    reject_start(257, "och_max_reject");
    do_load(16, 32'h0000_3000, 0, 1);
    serve_seq(17, 0);

    // 8-bit build: four biases per DMA word.
    for (int i = 0; i < 10; i++) b8[i] = 8'($urandom);
    bus8.och = 9'd10; bus8.bias_start_addr = 32'h40; bus8.ap_start = 1;
    step();
    bus8.ap_start = 0;
    check_eq("b8_start_dma", bus8.start_dma, 1);
    check_eq("b8_num_trans", bus8.dma_num_trans, 3);
    step();
    for (int w = 0; w < 3; w++) begin
      w8 = '0;
      for (int k = 0; k < 4; k++) w8[k*8 +: 8] = (w * 4 + k < 10) ? b8[w * 4 + k] : 8'hEE;
      bus8.dma_din = w8; bus8.dma_data_cnt = 18'(w); bus8.dma_din_vld = 1;
      step();
      bus8.dma_din_vld = 0;
    end
    bus8.dma_done = 1;
    step();
    bus8.dma_done = 0;
    for (int t = 0; t < 16 && !bus8.write_done; t++) step();
    check_eq("b8_write_done", bus8.write_done, 1);
    step();
    bus8.layer_swap = 1;
    step();
    bus8.layer_swap = 0;
    check_eq("b8_bank_vld", bus8.bias_bank_vld, 1);
    for (int i = 8; i < 11; i++) begin
      bus8.bias_request = 1; bus8.bias_mode = 1; bus8.bias_idx = 8'(i);
      step();
      check_eq("b8_idx_vld", bus8.bias_vld_o, 1);
      check_eq("b8_idx_bias", bus8.bias_o, (i < 10) ? 64'(b8[i]) : 64'd0);
      check_eq("b8_idx_err", bus8.err_o, (i < 10) ? 64'd0 : 64'd1);
    end
    bus8.bias_mode = 0;
    for (int i = 0; i < 11; i++) begin
      bus8.bias_request = 1;
      step();
      check_eq("b8_seq_bias", bus8.bias_o, 64'(b8[i % 10]));
    end
    bus8.bias_request = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
